// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared constants and types for the UART transmitter and receiver.
//   - Default baud-rate constants and the derived sample-tick period.
//   - Helper functions for the tick period and for counter widths.
//   - FSM state encoding used by the serial receiver.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int unsigned DEFAULT_DESIRED_FREQ = 9600;
    localparam int unsigned DEFAULT_BOARD_FREQ   = 100_000_000;
    localparam int unsigned DEFAULT_OVERSAMPLE   = 16;

    // Clock cycles per sample tick for a given board clock, baud rate and oversampling.
    function automatic int unsigned calc_tick_max(input int unsigned board_freq,
                                                  input int unsigned desired_freq,
                                                  input int unsigned oversample);
        return board_freq / (desired_freq * oversample);
    endfunction

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_TICK_MAX =
        calc_tick_max(DEFAULT_BOARD_FREQ, DEFAULT_DESIRED_FREQ, DEFAULT_OVERSAMPLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } serial_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Free-running divider producing a one-cycle Tick every TickMax clocks.
// Ports:
//   Clk   - system clock (rising edge)
//   Rst   - synchronous active-high reset
//   Clear - holds the divider at zero while high (no Tick emitted)
//   Tick  - one-cycle pulse when the divider wraps from TickMax-1 to 0
// -----------------------------------------------------------------------------
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int unsigned TickMax = DEFAULT_TICK_MAX
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick
);

    localparam int unsigned          CNT_W    = cnt_width(TickMax);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TickMax - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        Tick  = 1'b0;
        if (Clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            Tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/read_serial.sv
// -----------------------------------------------------------------------------
// read_serial
// 8N1 UART receiver with oversampled mid-bit sampling.
// Ports:
//   Clk          - system clock (rising edge)
//   Rst          - synchronous active-high reset
//   Rx           - asynchronous serial line, idle high
//   ReadEn       - receiver enable; low abandons any frame in progress
//   ByteAck      - consumer acknowledge, clears DataValid
//   readByte     - last correctly framed byte (LSB received first)
//   ByteReady    - one-cycle pulse when readByte is loaded
//   DataValid    - sticky flag: readByte not yet acknowledged
//   FramingError - one-cycle pulse when the stop bit is sampled low
//   Overrun      - one-cycle pulse when an unacknowledged byte is overwritten
// -----------------------------------------------------------------------------
module read_serial
    import serial_pkg::*;
#(
    parameter int unsigned DesiredFreq = DEFAULT_DESIRED_FREQ,
    parameter int unsigned BoardFreq   = DEFAULT_BOARD_FREQ,
    parameter int unsigned Oversample  = DEFAULT_OVERSAMPLE,
    parameter int unsigned TickMax     = calc_tick_max(BoardFreq, DesiredFreq, Oversample)
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       ReadEn,
    input  logic       ByteAck,
    output logic [7:0] readByte,
    output logic       ByteReady,
    output logic       DataValid,
    output logic       FramingError,
    output logic       Overrun
);

    localparam int unsigned         SAMPLE_W    = cnt_width(Oversample);
    localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(Oversample / 2 - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(Oversample - 1);

    logic rx_meta_q;
    logic rx_sync_q;

    serial_state_e       state_q,  state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [2:0]          bit_q,    bit_d;
    logic [7:0]          shift_q,  shift_d;

    logic [7:0] read_byte_q;
    logic       byte_ready_q;
    logic       data_valid_q;
    logic       framing_err_q;
    logic       overrun_q;

    logic tick;
    logic tick_clear;
    logic latch;
    logic frame_err;

    // The divider restarts from zero on every start-bit detection, so all
    // sample points are referenced to the detected falling edge.
    assign tick_clear = !ReadEn || (state_q == ST_IDLE);

    baud_tick_gen #(
        .TickMax (TickMax)
    ) u_tick_gen (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clear (tick_clear),
        .Tick  (tick)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        latch     = 1'b0;
        frame_err = 1'b0;
        if (!ReadEn) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_sync_q) begin
                        state_d  = ST_START;
                        sample_d = '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (sample_q == SAMPLE_MID) begin
                            // Line must still be low mid start bit, else it was a glitch.
                            if (!rx_sync_q) begin
                                state_d  = ST_DATA;
                                sample_d = '0;
                                bit_d    = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            sample_d = sample_q + SAMPLE_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (sample_q == SAMPLE_LAST) begin
                            // Shift right so the first bit received ends in bit 0.
                            shift_d  = {rx_sync_q, shift_q[7:1]};
                            sample_d = '0;
                            bit_d    = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_d = ST_STOP;
                            end
                        end else begin
                            sample_d = sample_q + SAMPLE_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (sample_q == SAMPLE_LAST) begin
                            // Leaving at mid stop bit lets a back-to-back start bit be seen.
                            if (rx_sync_q) begin
                                latch = 1'b1;
                            end else begin
                                frame_err = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            sample_d = sample_q + SAMPLE_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            sample_q      <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            read_byte_q   <= 8'h00;
            byte_ready_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            byte_ready_q  <= latch;
            framing_err_q <= frame_err;
            // An acknowledge on the latch cycle consumes the old byte, so no overrun.
            overrun_q     <= latch && data_valid_q && !ByteAck;
            if (latch) begin
                read_byte_q  <= shift_q;
                data_valid_q <= 1'b1;
            end else if (ByteAck) begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign readByte     = read_byte_q;
    assign ByteReady    = byte_ready_q;
    assign DataValid    = data_valid_q;
    assign FramingError = framing_err_q;
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_read_serial.sv
// -----------------------------------------------------------------------------
// tb_read_serial
// Directed vector bench for read_serial. The divider is scaled down
// (4 clocks per tick, 16 ticks per bit => 64 clocks per bit) to keep runs short.
// -----------------------------------------------------------------------------
module tb_read_serial;

    localparam int unsigned DESIRED  = 9600;
    localparam int unsigned OVERSAMP = 16;
    localparam int unsigned BOARD    = DESIRED * OVERSAMP * 4;
    localparam int          BIT_CLKS = 64;

    logic       Clk;
    logic       Rst;
    logic       Rx;
    logic       ReadEn;
    logic       ByteAck;
    logic [7:0] readByte;
    logic       ByteReady;
    logic       DataValid;
    logic       FramingError;
    logic       Overrun;

    read_serial #(
        .DesiredFreq (DESIRED),
        .BoardFreq   (BOARD),
        .Oversample  (OVERSAMP)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Rx           (Rx),
        .ReadEn       (ReadEn),
        .ByteAck      (ByteAck),
        .readByte     (readByte),
        .ByteReady    (ByteReady),
        .DataValid    (DataValid),
        .FramingError (FramingError),
        .Overrun      (Overrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Pulse-cycle counters: a pulse wider than one clock counts more than once.
    int cyc     = 0;
    int rdy_cnt = 0;
    int fe_cnt  = 0;
    int ovr_cnt = 0;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (ByteReady)    rdy_cnt <= rdy_cnt + 1;
        if (FramingError) fe_cnt  <= fe_cnt + 1;
        if (Overrun)      ovr_cnt <= ovr_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        Rx = 1'b0;
        idle(BIT_CLKS);
        for (int b = 0; b < 8; b++) begin
            Rx = data[b];
            idle(BIT_CLKS);
        end
        Rx = stop_bit;
        idle(BIT_CLKS);
        Rx = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge Clk);
        ByteAck = 1'b1;
        @(negedge Clk);
        ByteAck = 1'b0;
    endtask

    typedef struct {
        logic       ack_before;
        logic [7:0] data;
        logic       stop_bit;
        int         exp_ready;
        int         exp_ferr;
        int         exp_ovr;
        logic [7:0] exp_byte;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [6];

    int r0, f0, o0;
    int c1;
    logic got;

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1, 0, 0, 8'hA5, 1'b1};
        vecs[1] = '{1'b0, 8'h3C, 1'b0, 0, 1, 0, 8'hA5, 1'b1};
        vecs[2] = '{1'b0, 8'h11, 1'b1, 1, 0, 1, 8'h11, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 1, 0, 0, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 8'hC3, 1'b0, 0, 1, 0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'hFF, 1'b1, 1, 0, 0, 8'hFF, 1'b1};

        Rst = 1'b1; Rx = 1'b1; ReadEn = 1'b1; ByteAck = 1'b0;
        idle(3);
        Rst = 1'b0;
        idle(2);
        check("reset_readByte",     32'(readByte),     32'h00);
        check("reset_ByteReady",    32'(ByteReady),    32'h0);
        check("reset_DataValid",    32'(DataValid),    32'h0);
        check("reset_FramingError", 32'(FramingError), 32'h0);
        check("reset_Overrun",      32'(Overrun),      32'h0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].ack_before) ack_pulse();
            idle(4);
            r0 = rdy_cnt; f0 = fe_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            idle(2 * BIT_CLKS);
            $display("vec %0d: data=%h stop=%0b -> readByte=%h valid=%0b", i,
                     vecs[i].data, vecs[i].stop_bit, readByte, DataValid);
            check($sformatf("vec%0d_ready", i), 32'(rdy_cnt - r0), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_ferr", i),  32'(fe_cnt - f0),  32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i),   32'(ovr_cnt - o0), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_byte", i),  32'(readByte),     32'(vecs[i].exp_byte));
            check($sformatf("vec%0d_valid", i), 32'(DataValid),    32'(vecs[i].exp_valid));
        end

        // Short low glitch on the idle line: false start, then a clean frame.
        r0 = rdy_cnt; f0 = fe_cnt;
        Rx = 1'b0;
        idle(12);
        Rx = 1'b1;
        idle(2 * BIT_CLKS);
        check("glitch_ready", 32'(rdy_cnt - r0), 32'd0);
        check("glitch_ferr",  32'(fe_cnt - f0),  32'd0);
        send_frame(8'h96, 1'b1);
        idle(2 * BIT_CLKS);
        check("after_glitch_ready", 32'(rdy_cnt - r0), 32'd1);
        check("after_glitch_byte",  32'(readByte),     32'h96);

        // Back-to-back 0x11, 0x22 without acknowledge.
        ack_pulse();
        idle(4);
        r0 = rdy_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2 * BIT_CLKS);
        check("b2b_ready", 32'(rdy_cnt - r0), 32'd2);
        check("b2b_ovr",   32'(ovr_cnt - o0), 32'd1);
        check("b2b_byte",  32'(readByte),     32'h22);
        check("b2b_valid", 32'(DataValid),    32'h1);

        // Back-to-back 0x33, 0x44 with ByteAck on the second latch cycle.
        // Frames start exactly 10 bits apart, so the second latch follows the
        // first one by the same number of clocks.
        r0 = rdy_cnt; o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h33, 1'b1);
                send_frame(8'h44, 1'b1);
            end
            begin
                got = 1'b0;
                for (int k = 0; k < 1500; k++) begin
                    @(negedge Clk);
                    if (ByteReady) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("ackl_first_ready_seen", 32'(got), 32'h1);
                if (got) begin
                    c1 = cyc;
                    while (cyc < c1 + 10 * BIT_CLKS - 1) @(negedge Clk);
                    ByteAck = 1'b1;
                    @(negedge Clk);
                    check("ackl_ready",   32'(ByteReady), 32'h1);
                    check("ackl_overrun", 32'(Overrun),   32'h0);
                    check("ackl_valid",   32'(DataValid), 32'h1);
                    ByteAck = 1'b0;
                end
            end
        join
        idle(2 * BIT_CLKS);
        check("ackl_ready_total", 32'(rdy_cnt - r0), 32'd2);
        check("ackl_ovr_total",   32'(ovr_cnt - o0), 32'd1);
        check("ackl_byte",        32'(readByte),     32'h44);
        check("ackl_valid_after", 32'(DataValid),    32'h1);

        // Reset during bit 4 of 0x5A, held to the end of that frame, then 0xC3.
        r0 = rdy_cnt; f0 = fe_cnt; o0 = ovr_cnt;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(5 * BIT_CLKS + BIT_CLKS / 2);
                Rst = 1'b1;
                idle(5 * BIT_CLKS);
                Rst = 1'b0;
            end
        join
        idle(BIT_CLKS);
        check("rst_pulses",    32'(rdy_cnt - r0 + fe_cnt - f0 + ovr_cnt - o0), 32'd0);
        check("rst_readByte",  32'(readByte),  32'h00);
        check("rst_DataValid", 32'(DataValid), 32'h0);
        send_frame(8'hC3, 1'b1);
        idle(2 * BIT_CLKS);
        check("rst_c3_ready", 32'(rdy_cnt - r0), 32'd1);
        check("rst_c3_byte",  32'(readByte),     32'hC3);

        // Drop ReadEn mid-frame of 0xFF; ByteAck still works while disabled.
        r0 = rdy_cnt; f0 = fe_cnt; o0 = ovr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(3 * BIT_CLKS + 20);
                ReadEn = 1'b0;
                idle(8);
                check("dis_valid_kept", 32'(DataValid), 32'h1);
                ack_pulse();
                idle(2);
                check("dis_ack_valid", 32'(DataValid), 32'h0);
            end
        join
        idle(BIT_CLKS);
        ReadEn = 1'b1;
        idle(BIT_CLKS);
        check("dis_pulses", 32'(rdy_cnt - r0 + fe_cnt - f0 + ovr_cnt - o0), 32'd0);
        check("dis_byte",   32'(readByte), 32'hC3);
        send_frame(8'h00, 1'b1);
        idle(2 * BIT_CLKS);
        check("en_00_ready", 32'(rdy_cnt - r0), 32'd1);
        check("en_00_byte",  32'(readByte),     32'h00);
        check("en_00_valid", 32'(DataValid),    32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/read_serial.md
READ_SERIAL -- requirements
Module: read_serial

Interface
REQ-001 The block SHALL have parameter DesiredFreq, default 9600, giving the serial bit rate in baud.
REQ-002 The block SHALL have parameter BoardFreq, default 100000000, giving the Clk frequency in Hz.
REQ-003 The block SHALL have parameter Oversample, default 16, giving the number of sample ticks per bit.
REQ-004 The block SHALL have parameter TickMax, default BoardFreq/(DesiredFreq*Oversample) = 651, giving Clk cycles per sample tick.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port Rx, input, 1 bit: asynchronous serial line, 8N1, idle high.
REQ-008 The block SHALL have port ReadEn, input, 1 bit: receiver enable.
REQ-009 The block SHALL have port ByteAck, input, 1 bit: consumer acknowledge; clears DataValid.
REQ-010 The block SHALL have port readByte, output, 8 bits: last correctly framed byte, LSB received first.
REQ-011 The block SHALL have port ByteReady, output, 1 bit: one-Clk pulse when a new byte is latched.
REQ-012 The block SHALL have port DataValid, output, 1 bit: sticky flag meaning readByte is unconsumed.
REQ-013 The block SHALL have port FramingError, output, 1 bit: one-Clk pulse when a stop bit is sampled low.
REQ-014 The block SHALL have port Overrun, output, 1 bit: one-Clk pulse when a byte is latched while DataValid=1 and ByteAck=0.

Function
REQ-015 Rx SHALL pass through a 2-flop synchronizer initialised to 1, and only the synchronized value SHALL be used.
REQ-016 A tick counter SHALL count 0..TickMax-1, emitting a one-Clk tick at the wrap; it SHALL be held at 0 while ReadEn=0 or the FSM is in IDLE.
REQ-017 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-018 IDLE -> START SHALL occur on the first Clk with synchronized Rx=0 and ReadEn=1, clearing the sample count.
REQ-019 In START, on the tick where the sample count reaches Oversample/2-1 (mid start bit): Rx=0 -> DATA with the sample count cleared; Rx=1 -> IDLE (false start, no outputs).
REQ-020 In DATA, every Oversample ticks (mid bit) Rx SHALL be shifted into bit position 0..7 in order; after bit 7 the FSM SHALL go to STOP.
REQ-021 In STOP, at mid stop bit: Rx=1 -> readByte loaded, ByteReady=1 and DataValid=1 on the next Clk; Rx=0 -> FramingError=1 for one Clk, with readByte and DataValid unchanged. Both cases SHALL then return to IDLE.
REQ-022 Latency from the line falling edge to ByteReady SHALL be 9.5 bit times plus 3 Clk cycles, within 1 tick.
REQ-023 ByteAck=1 SHALL clear DataValid on the next Clk; when ByteAck coincides with a byte latch, DataValid SHALL stay 1 and Overrun SHALL stay 0.
REQ-024 On overrun, readByte SHALL be overwritten with the new byte, Overrun SHALL pulse, and DataValid SHALL remain 1.
REQ-025 ReadEn=0 SHALL force the FSM to IDLE on the next Clk, abandon any partial frame without pulses, and retain readByte and DataValid; ByteAck SHALL still be honoured.
REQ-026 Back-to-back frames, with the next start bit immediately after the stop bit, SHALL be received without loss.

Reset
REQ-027 On Rst=1 at a Clk edge: FSM=IDLE, tick and sample counters=0, shift register=0, synchronizer=11, readByte=8'h00, ByteReady=0, DataValid=0, FramingError=0, Overrun=0.
REQ-028 Rst SHALL take priority over all other inputs, including mid-frame, and no pulse SHALL be generated for an aborted frame.

Structure
REQ-029 The baud constants (DesiredFreq, BoardFreq, Oversample, derived TickMax and counter widths) and the FSM state encoding SHALL live in a shared serial package used by both the transmitter and read_serial.
REQ-030 The sample-tick generator SHALL be a sub-module named baud_tick_gen with ports Clk, Rst, Clear and Tick.

Verification
REQ-031 Send 0xA5 at 9600 baud with ReadEn=1: ByteReady pulses once, readByte=8'hA5, DataValid=1.
REQ-032 Drive a 20 us low glitch on idle Rx: no ByteReady, no FramingError, and the FSM returns to IDLE.
REQ-033 Send 0x3C with the stop bit forced low: FramingError pulses once and readByte/DataValid keep their prior values.
REQ-034 Send 0x11 then 0x22 back-to-back without ByteAck: the second latch gives Overrun=1 pulse and readByte=8'h22; repeat with ByteAck on the latch cycle and expect no Overrun.
REQ-035 Assert Rst during bit 4 of 0x5A, release it, then send 0xC3: no output for 0x5A; readByte=8'hC3 with a single ByteReady.
REQ-036 Drop ReadEn mid-frame of 0xFF, then re-enable and send 0x00: no pulse for 0xFF; readByte=8'h00.
